// File: rtl/aes_pkg.sv
// AES GF(2^8) helpers, state typedefs and FSM encoding shared by the
// InvMixColumns slice (xtime chains only, no general multiplier).
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         AES_NCOL = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // index 3 holds column 0 so the packed view matches in[127:96]
    typedef logic [AES_NCOL-1:0][31:0] aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational single-column InvMixColumns (optionally forward MixColumns).
// Ports: col_i (32b column, a0 in [31:24]), col_o (mixed column), fwd_i
// (only with INV_MIX_COLUMNS_FWD_EN: 1 selects the forward matrix).
module inv_mix_single_column
    import aes_pkg::*;
(
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic        fwd_i,
`endif
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [31:0] inv_col;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign inv_col[31:24] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul9(a3);
    assign inv_col[23:16] = gf_mul9(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
    assign inv_col[15:8]  = gf_mul0d(a0) ^ gf_mul9(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
    assign inv_col[7:0]   = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul9(a2) ^ gf_mul0e(a3);

`ifdef INV_MIX_COLUMNS_FWD_EN
    logic [7:0]  t0, t1, t2, t3;
    logic [31:0] fwd_col;

    assign t0 = xtime(a0);
    assign t1 = xtime(a1);
    assign t2 = xtime(a2);
    assign t3 = xtime(a3);

    // 3*x == xtime(x) ^ x
    assign fwd_col[31:24] = t0 ^ t1 ^ a1 ^ a2 ^ a3;
    assign fwd_col[23:16] = a0 ^ t1 ^ t2 ^ a2 ^ a3;
    assign fwd_col[15:8]  = a0 ^ a1 ^ t2 ^ t3 ^ a3;
    assign fwd_col[7:0]   = t0 ^ a0 ^ a1 ^ a2 ^ t3;

    assign col_o = fwd_i ? fwd_col : inv_col;
`else
    assign col_o = inv_col;
`endif

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES-128 InvMixColumns: one column per clock, start/busy/done.
// Ports: clk, reset_n (async low), start, in/out (128b state), busy, done,
// fwd (only with INV_MIX_COLUMNS_FWD_EN: 1 = forward MixColumns).
module inv_mix_columns_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic         fwd,
`endif
    input  logic [127:0] in,
    output logic [127:0] out,
    output logic         busy,
    output logic         done
);

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    aes_state_t   work_q, work_d;
    logic [127:0] out_q, out_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [1:0]   col_idx;
    logic [31:0]  col_in, col_out;

`ifdef INV_MIX_COLUMNS_FWD_EN
    logic fwd_q, fwd_d;
`endif

    // column 0 lives in the top word of the packed state
    assign col_idx = 2'd3 - col_q;
    assign col_in  = work_q[col_idx];

    inv_mix_single_column u_col (
`ifdef INV_MIX_COLUMNS_FWD_EN
        .fwd_i (fwd_q),
`endif
        .col_i (col_in),
        .col_o (col_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef INV_MIX_COLUMNS_FWD_EN
            fwd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef INV_MIX_COLUMNS_FWD_EN
            fwd_q   <= fwd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef INV_MIX_COLUMNS_FWD_EN
        fwd_d   = fwd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    work_d  = in;
                    col_d   = 2'd0;
                    busy_d  = 1'b1;
`ifdef INV_MIX_COLUMNS_FWD_EN
                    fwd_d   = fwd;
`endif
                end
            end
            RUN: begin
                work_d[col_idx] = col_out;
                col_d           = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = IDLE;
                    out_d   = work_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
